// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result bundle between a requester and the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  modport master (output start, a, b, borrow_in, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, borrow_in, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in using one full-subtractor cell
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_z, r_busy, r_done, r_bo;
  logic             w_d, w_z_nxt, w_last;
  logic [WIDTH-1:0] w_res_nxt;
  assign w_d     = r_a[0] ^ r_b[0] ^ r_z;
  assign w_z_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_z);
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  // new difference bit enters at the MSB so the word is aligned once all bits are in
  always_comb begin
    w_res_nxt = r_res >> 1;
    w_res_nxt[WIDTH-1] = w_d;
  end
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_bo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_z     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bo    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_z     <= bus.borrow_in;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_z   <= w_z_nxt;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff  <= w_res_nxt;
            r_bo    <= w_z_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the bit-serial subtractor at WIDTH 1, 8 and 16
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        st[3];
  logic [31:0] av[3], bv[3];
  logic        bi[3];
  logic        busy_o[3], done_o[3], bo_o[3];
  logic [31:0] dif_o[3];
  int          wd[3] = '{1, 8, 16};
  int          n_pass = 0, n_tot = 0;
  serial_subtractor_if #(.WIDTH(1))  i1();
  serial_subtractor_if #(.WIDTH(8))  i8();
  serial_subtractor_if #(.WIDTH(16)) i16();
  serial_subtractor #(.WIDTH(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  serial_subtractor #(.WIDTH(8))  u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  assign i1.start = st[0];  assign i1.a = av[0][0:0];   assign i1.b = bv[0][0:0];   assign i1.borrow_in = bi[0];
  assign i8.start = st[1];  assign i8.a = av[1][7:0];   assign i8.b = bv[1][7:0];   assign i8.borrow_in = bi[1];
  assign i16.start = st[2]; assign i16.a = av[2][15:0]; assign i16.b = bv[2][15:0]; assign i16.borrow_in = bi[2];
  assign busy_o[0] = i1.busy;  assign done_o[0] = i1.done;  assign bo_o[0] = i1.borrow_out;  assign dif_o[0] = 32'(i1.diff);
  assign busy_o[1] = i8.busy;  assign done_o[1] = i8.done;  assign bo_o[1] = i8.borrow_out;  assign dif_o[1] = 32'(i8.diff);
  assign busy_o[2] = i16.busy; assign done_o[2] = i16.done; assign bo_o[2] = i16.borrow_out; assign dif_o[2] = 32'(i16.diff);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // counts negedges after the accepting edge until done, and busy samples seen before it
  task automatic wait_done(input int k, output int lat, output int nb);
    lat = 0;
    nb = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done_o[k]) break;
      if (busy_o[k]) nb++;
      if (lat > 100) begin
        chk("done_timeout", 32'(lat), 32'(wd[k] + 1));
        break;
      end
    end
  endtask
  task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic bin,
                    output logic [31:0] d, output logic bo);
    int lat, nb;
    av[k] = a; bv[k] = b; bi[k] = bin; st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    av[k] = $urandom; bv[k] = $urandom; bi[k] = 1'($urandom);
    wait_done(k, lat, nb);
    chk("latency", 32'(lat), 32'(wd[k] + 1));
    chk("busy_cycles", 32'(nb), 32'(wd[k]));
    d = dif_o[k];
    bo = bo_o[k];
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o[k]), 32'd0);
  endtask
  initial begin
    logic [31:0] d, ea, eb, mask;
    logic        bo;
    logic [7:0]  t1d, t1b;
    longint      t;
    int          lat, nb, cnt;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; av[k] = '0; bv[k] = '0; bi[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 32'(busy_o[k]), 32'd0);
      chk("rst_done", 32'(done_o[k]), 32'd0);
      chk("rst_diff", dif_o[k], 32'd0);
      chk("rst_bo", 32'(bo_o[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    t1d = 8'b1001_0110;
    t1b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      op(0, 32'(i[2]), 32'(i[1]), i[0], d, bo);
      chk($sformatf("w1_diff_%0d", i), d, 32'(t1d[i]));
      chk($sformatf("w1_bo_%0d", i), 32'(bo), 32'(t1b[i]));
    end
    op(1, 32'h05, 32'h03, 1'b0, d, bo);
    chk("w8_5m3_diff", d, 32'h02);  chk("w8_5m3_bo", 32'(bo), 32'd0);
    op(1, 32'h03, 32'h05, 1'b0, d, bo);
    chk("w8_3m5_diff", d, 32'hFE);  chk("w8_3m5_bo", 32'(bo), 32'd1);
    op(1, 32'h00, 32'hFF, 1'b1, d, bo);
    chk("w8_0mff_diff", d, 32'h00); chk("w8_0mff_bo", 32'(bo), 32'd1);
    av[1] = 32'h20; bv[1] = 32'h01; bi[1] = 1'b0; st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (3) @(negedge clk);
    av[1] = 32'hFF; bv[1] = 32'h00; st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (2) @(negedge clk);
    av[1] = 32'h10; bv[1] = 32'h01; st[1] = 1'b1;
    wait_done(1, lat, nb);
    chk("b2b_first_diff", dif_o[1], 32'h1F);
    chk("b2b_first_bo", 32'(bo_o[1]), 32'd0);
    @(posedge clk);
    #1 st[1] = 1'b0;
    wait_done(1, lat, nb);
    chk("b2b_second_lat", 32'(lat), 32'd9);
    chk("b2b_second_diff", dif_o[1], 32'h0F);
    chk("b2b_second_bo", 32'(bo_o[1]), 32'd0);
    @(negedge clk);
    av[1] = 32'h55; bv[1] = 32'h11; bi[1] = 1'b0; st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_diff", dif_o[1], 32'd0);
    chk("abort_bo", 32'(bo_o[1]), 32'd0);
    chk("abort_busy", 32'(busy_o[1]), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[1] || busy_o[1]) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    op(1, 32'h80, 32'h01, 1'b0, d, bo);
    chk("post_rst_diff", d, 32'h7F);
    chk("post_rst_bo", 32'(bo), 32'd0);
    for (int k = 1; k < 3; k++) begin
      mask = (k == 1) ? 32'hFF : 32'hFFFF;
      for (int i = 0; i < 1000; i++) begin
        ea = $urandom & mask;
        eb = $urandom & mask;
        bi[k] = 1'($urandom);
        bo = bi[k];
        t = longint'(ea) - longint'(eb) - longint'(bo);
        op(k, ea, eb, bo, d, bo);
        chk("rand_diff", d, 32'(t) & mask);
        chk("rand_bo", 32'(bo), 32'(t < 0));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor built around one full-subtractor cell and a registered borrow. It sits directly downstream of the gate-level full subtractor and sequences it over multi-bit operands, processing one bit per clock, LSB first. The operands and borrow-in are latched on a start pulse. The block then returns a registered difference, borrow-out and a one-cycle done strobe. It is the multi-bit arithmetic stage that consumes the full-subtractor cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to clk.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  minuend x; latched on accepted start.
- b  input  WIDTH  subtrahend y; latched on accepted start.
- borrow_in  input  1  initial borrow z into bit 0; latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff/borrow_out valid from this cycle.
- diff  output  WIDTH  registered result (a - b - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  borrow out of bit WIDTH-1.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: processing one bit per cycle.
  - DONE: single cycle that asserts done.
- IDLE/DONE + start=1: latch a, b and borrow_in into internal operand shift registers and borrow flop, clear the bit counter, go to SHIFT. start while busy=1 is ignored; no queuing.
- SHIFT, per edge, with x=a_sr[0], y=b_sr[0], z=borrow flop:
  - difference bit d = x^y^z
  - next borrow = (~x&y) | (~(x^y)&z)
  - d shifts into the MSB of the internal result register; a_sr and b_sr shift right; counter increments.
- Exit: on the edge that processes bit WIDTH-1, copy the result register to diff and the final borrow to borrow_out, then go to DONE.
- DONE: done=1 for exactly one cycle. The next edge goes to IDLE, or to SHIFT if start=1.
- diff and borrow_out hold their value until the next completion; intermediate bits are never visible on diff.
- busy = (state==SHIFT).
- Arithmetic: diff = (a - b - borrow_in) mod 2^WIDTH. borrow_out=1 iff a < b + borrow_in (unsigned).

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0, state=IDLE, counter/shift registers/borrow flop=0.
- Start accepted at edge E0:
  - busy=1 from E0 through E0+WIDTH.
  - Bits are processed at edges E0+1 .. E0+WIDTH.
  - done=1, busy=0 and the new diff/borrow_out are visible in the cycle after edge E0+WIDTH, i.e. WIDTH+1 edges after acceptance.
- Back-to-back: start=1 during the DONE cycle is accepted. Throughput is one operation per WIDTH+1 cycles.
- WIDTH=1: a single SHIFT cycle. The result equals one full-subtractor evaluation of (a, b, borrow_in).
- rst_n asserted mid-operation aborts immediately:
  - all outputs return to reset values and no done is produced.
  - the first start after release starts a fresh operation.
- Inputs a, b and borrow_in may change freely after the accepting edge without affecting the result.

## Test plan
- WIDTH=1, all 8 (a,b,borrow_in) combinations -> (diff,borrow_out) = 000→0,0; 001→1,1; 010→1,1; 011→0,1; 100→1,0; 101→0,0; 110→0,0; 111→1,1. Each done arrives 2 edges after start.
- WIDTH=8, a=0x05, b=0x03, borrow_in=0 -> diff=0x02, borrow_out=0, done 9 edges after the start edge, busy high for exactly 8 cycles.
- WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0xFF, borrow_in=1 -> diff=0x00, borrow_out=1.
- WIDTH=8, start re-pulsed with a=0xFF during busy, then start held high through DONE with a=0x10, b=0x01 -> busy-time pulse ignored (first result unchanged), second operation starts in the DONE cycle, diff=0x0F.
- WIDTH=8, rst_n low for 1 cycle at edge E0+4 of an operation -> diff=0, borrow_out=0, busy=0, no done. A subsequent start with a=0x80, b=0x01 -> diff=0x7F, borrow_out=0.
- Randomized 1000 operations at WIDTH=8 and WIDTH=16 against a reference model of (a - b - borrow_in) -> zero mismatches, exactly one done per accepted start.
